// File: rtl/qspi_flash_responder.sv
// QSPI flash target: serves 0xEB quad fast-read (with continuous-read mode) and 0x9F JEDEC ID
// from a byte-wide backing memory, oversampling SCK/CS_n on clk.
//   state  | meaning
//   IDLE   | deselected; waits for cs_n low
//   CMD    | shifting command byte on DQ0
//   ADDR   | shifting 6 address nibbles
//   MODE   | shifting mode byte (sets/clears continuous-read)
//   DUMMY  | turnaround cycles, DQ ignored
//   DATA   | streaming nibbles from memory
//   ID     | streaming JEDEC ID on DQ1
//   IGNORE | unsupported command; waits for cs_n high
module qspi_flash_responder #(
  parameter int          ADDR_W   = 24,
  parameter int          DUMMY    = 4,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              qspi_sck,
  input  logic              qspi_cs_n,
  input  logic [3:0]        qspi_dq_i,
  output logic [3:0]        qspi_dq_o,
  output logic [3:0]        qspi_dq_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_ID, S_IGNORE
  } state_t;

  state_t      state, state_nx;
  logic        sck_q;
  logic        rise, fall, tc;
  logic [7:0]  cnt;
  logic        nib_lo;
  logic [6:0]  cmd_sh;
  logic [7:0]  cmd_byte;
  logic [19:0] addr_sh;
  logic [23:0] addr_full;
  logic [1:0]  mode_hi;
  logic        cont;
  logic        rd_pend;
  logic [7:0]  next_byte, cur_byte;
  logic        drive_hi, drive_lo;

  assign rise      = qspi_sck & ~sck_q;
  assign fall      = ~qspi_sck & sck_q;
  assign tc        = (cnt == 8'd0);
  assign cmd_byte  = {cmd_sh, qspi_dq_i[0]};
  assign addr_full = {addr_sh, qspi_dq_i};
  // the fall that leaves DUMMY doubles as the first high-nibble fall of DATA
  assign drive_hi  = fall && ((state == S_DUMMY && tc) || (state == S_DATA && !nib_lo));
  assign drive_lo  = fall && state == S_DATA && nib_lo;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (qspi_cs_n) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nx = cont ? S_ADDR : S_CMD;
        S_CMD:
          if (rise && tc) begin
            if (cmd_byte == 8'hEB)      state_nx = S_ADDR;
            else if (cmd_byte == 8'h9F) state_nx = S_ID;
            else                        state_nx = S_IGNORE;
          end
        S_ADDR:  if (rise && tc) state_nx = S_MODE;
        S_MODE:  if (rise && tc) state_nx = S_DUMMY;
        S_DUMMY: if (fall && tc) state_nx = S_DATA;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_q      <= 1'b0;
      cnt        <= 8'd0;
      nib_lo     <= 1'b0;
      cmd_sh     <= '0;
      addr_sh    <= '0;
      mode_hi    <= '0;
      cont       <= 1'b0;
      rd_pend    <= 1'b0;
      next_byte  <= '0;
      cur_byte   <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      qspi_dq_o  <= '0;
      qspi_dq_oe <= '0;
    end else begin
      sck_q  <= qspi_sck;
      mem_rd <= 1'b0;
      if (qspi_cs_n) begin
        // deselect drops any read still in flight; cont survives
        cnt        <= 8'd0;
        nib_lo     <= 1'b0;
        rd_pend    <= 1'b0;
        qspi_dq_o  <= '0;
        qspi_dq_oe <= '0;
      end else begin
        rd_pend <= mem_rd;
        if (rd_pend) next_byte <= mem_data;
        case (state)
          S_IDLE: begin
            cnt    <= cont ? 8'd5 : 8'd7;
            nib_lo <= 1'b0;
          end
          S_CMD:
            if (rise) begin
              cmd_sh <= cmd_byte[6:0];
              if (tc) cnt <= (cmd_byte == 8'hEB) ? 8'd5 : 8'd23;
              else    cnt <= cnt - 8'd1;
            end
          S_ADDR:
            if (rise) begin
              addr_sh <= addr_full[19:0];
              if (tc) begin
                mem_addr <= addr_full[ADDR_W-1:0];
                mem_rd   <= 1'b1;
                cnt      <= 8'd1;
              end else begin
                cnt <= cnt - 8'd1;
              end
            end
          S_MODE:
            if (rise) begin
              if (tc) begin
                cont <= (mode_hi == 2'b10);
                cnt  <= 8'(DUMMY);
              end else begin
                mode_hi <= qspi_dq_i[1:0];
                cnt     <= cnt - 8'd1;
              end
            end
          S_DUMMY: if (rise && !tc) cnt <= cnt - 8'd1;
          S_ID:
            if (fall) begin
              qspi_dq_o  <= {2'b00, JEDEC_ID[cnt[4:0]], 1'b0};
              qspi_dq_oe <= 4'b0010;
              cnt        <= tc ? 8'd23 : cnt - 8'd1;
            end
          default: ;
        endcase
        if (drive_hi) begin
          qspi_dq_o  <= next_byte[7:4];
          qspi_dq_oe <= 4'b1111;
          cur_byte   <= next_byte;
          mem_addr   <= mem_addr + 1'b1;
          mem_rd     <= 1'b1;
          nib_lo     <= 1'b1;
        end
        if (drive_lo) begin
          qspi_dq_o <= cur_byte[3:0];
          nib_lo    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench for qspi_flash_responder: acts as QSPI controller and as backing memory.
module tb_qspi_flash_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        qspi_sck = 1'b0;
  logic        qspi_cs_n = 1'b1;
  logic [3:0]  qspi_dq_i = 4'h0;
  logic [3:0]  qspi_dq_o, qspi_dq_oe;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data = 8'h00;

  int n_pass = 0, n_total = 0, n_fail = 0;
  logic [3:0]  rd_dq, rd_oe;
  logic [23:0] rd_log[$];

  qspi_flash_responder dut (
    .clk(clk), .rst(rst), .qspi_sck(qspi_sck), .qspi_cs_n(qspi_cs_n),
    .qspi_dq_i(qspi_dq_i), .qspi_dq_o(qspi_dq_o), .qspi_dq_oe(qspi_dq_oe),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_model(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      24'hFFFFFF: return 8'h5C;
      24'h000000: return 8'hC3;
      default:    return a[7:0] ^ 8'h69;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_data <= mem_model(mem_addr);
      rd_log.push_back(mem_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one SCK period: fall at start, controller samples just before the rise
  task automatic sck_cycle(input logic [3:0] d);
    qspi_sck  = 1'b0;
    qspi_dq_i = d;
    repeat (3) @(negedge clk);
    rd_dq = qspi_dq_o;
    rd_oe = qspi_dq_oe;
    qspi_sck = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic cs_begin();
    qspi_cs_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // deselect while SCK is high so the trailing fall is never seen
  task automatic cs_end();
    qspi_cs_n = 1'b1;
    @(negedge clk);
    check("cs_oe", 32'(qspi_dq_oe), 32'h0);
    @(negedge clk);
    qspi_sck = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sck_cycle({3'b000, b[i]});
  endtask

  task automatic send_addr_mode(input logic [23:0] a, input logic [7:0] m, output logic [3:0] ta_oe);
    for (int i = 5; i >= 0; i--) sck_cycle(a[i*4 +: 4]);
    ta_oe = 4'h0;
    sck_cycle(m[7:4]); ta_oe |= rd_oe;
    sck_cycle(m[3:0]); ta_oe |= rd_oe;
    repeat (4) begin sck_cycle(4'h0); ta_oe |= rd_oe; end
  endtask

  task automatic read_bytes(input int n, output logic [31:0] data, output logic [3:0] oe_and);
    data = '0;
    oe_and = 4'hF;
    for (int i = 0; i < 2 * n; i++) begin
      sck_cycle(4'h0);
      data = {data[27:0], rd_dq};
      oe_and &= rd_oe;
    end
  endtask

  task automatic read_id(output logic [23:0] id, output logic [3:0] oe_or);
    id = '0;
    oe_or = 4'h0;
    for (int i = 0; i < 24; i++) begin
      sck_cycle(4'h0);
      id = {id[22:0], rd_dq[1]};
      oe_or |= rd_oe;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] data;
    logic [23:0] id;
    logic [3:0]  oe_v, ta_oe;

    repeat (3) @(negedge clk);
    check("rst_dq_o", 32'(qspi_dq_o), 32'h0);
    check("rst_oe", 32'(qspi_dq_oe), 32'h0);
    check("rst_mem_rd", 32'(mem_rd), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // JEDEC ID, twice round the 24-bit loop
    cs_begin();
    send_cmd(8'h9F);
    read_id(id, oe_v);
    check("id_first", 32'(id), 32'hEF4018);
    check("id_oe", 32'(oe_v), 32'h2);
    read_id(id, oe_v);
    check("id_repeat", 32'(id), 32'hEF4018);
    cs_end();

    // quad read of 4 bytes; the last high nibble prefetches 0x104
    rd_log.delete();
    cs_begin();
    send_cmd(8'hEB);
    send_addr_mode(24'h000100, 8'h00, ta_oe);
    check("turnaround_oe", 32'(ta_oe), 32'h0);
    read_bytes(4, data, oe_v);
    check("quad_data", data, 32'h11223344);
    check("quad_oe", 32'(oe_v), 32'hF);
    cs_end();
    check("quad_rd_count", 32'(rd_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < rd_log.size(); i++)
      check("quad_rd_addr", 32'(rd_log[i]), 32'h100 + 32'(i));

    // continuous read: 0xA0 enables, next transaction has no command, 0xFF disables
    cs_begin();
    send_cmd(8'hEB);
    send_addr_mode(24'h000100, 8'hA0, ta_oe);
    read_bytes(2, data, oe_v);
    check("cont_first", data, 32'h1122);
    cs_end();
    cs_begin();
    send_addr_mode(24'h000102, 8'hFF, ta_oe);
    check("cont_turnaround_oe", 32'(ta_oe), 32'h0);
    read_bytes(2, data, oe_v);
    check("cont_second", data, 32'h3344);
    cs_end();
    cs_begin();
    send_cmd(8'h9F);
    read_id(id, oe_v);
    check("cont_cleared_id", 32'(id), 32'hEF4018);
    cs_end();

    // address wrap
    rd_log.delete();
    cs_begin();
    send_cmd(8'hEB);
    send_addr_mode(24'hFFFFFF, 8'h00, ta_oe);
    read_bytes(2, data, oe_v);
    check("wrap_data", data, 32'h5CC3);
    cs_end();
    check("wrap_rd_count", 32'(rd_log.size()), 32'd3);
    if (rd_log.size() >= 2) begin
      check("wrap_rd0", 32'(rd_log[0]), 32'hFFFFFF);
      check("wrap_rd1", 32'(rd_log[1]), 32'h000000);
    end

    // abort after 3 address nibbles
    rd_log.delete();
    cs_begin();
    send_cmd(8'hEB);
    sck_cycle(4'h0); sck_cycle(4'h0); sck_cycle(4'h1);
    cs_end();
    check("abort_no_rd", 32'(rd_log.size()), 32'd0);
    cs_begin();
    send_cmd(8'h9F);
    read_id(id, oe_v);
    check("abort_then_id", 32'(id), 32'hEF4018);
    cs_end();

    // reset mid-DATA after a mode byte that would set continuous-read
    cs_begin();
    send_cmd(8'hEB);
    send_addr_mode(24'h000100, 8'hA0, ta_oe);
    read_bytes(1, data, oe_v);
    check("pre_rst_data", data, 32'h11);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_dq_o", 32'(qspi_dq_o), 32'h0);
    check("mid_rst_oe", 32'(qspi_dq_oe), 32'h0);
    check("mid_rst_mem_rd", 32'(mem_rd), 32'h0);
    check("mid_rst_mem_addr", 32'(mem_addr), 32'h0);
    rst = 1'b1;
    cs_end();
    cs_begin();
    send_cmd(8'hEB);
    send_addr_mode(24'h000102, 8'h00, ta_oe);
    read_bytes(2, data, oe_v);
    check("post_rst_data", data, 32'h3344);
    cs_end();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
